pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush scheduler for the five-stage core. It merges stall requests from IF (fetch pending), ID (load-use) and MEM (data port busy), plus taken-branch/jump resolution from EX. From these it drives the one-hot `stall` vector and the `clear` flush consumed by the IF/ID and ID/EX pipeline registers, and the PC redirect consumed by the fetch unit. It tracks a flush that arrives while MEM holds the pipeline, and keeps two saturating performance counters.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk_in`  in  1  core clock; all state updates on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global ready; low freezes the core.
- `if_stall_req`  in  1  IF fetch not yet complete.
- `id_load_use`  in  1  ID source register matches the rd of a load currently in EX.
- `mem_stall_req`  in  1  MEM data access not yet complete.
- `ex_jump`  in  1  EX resolved a taken branch or jump this cycle.
- `ex_jump_pc`  in  32  target of `ex_jump`.
- `perf_clr`  in  1  synchronous clear of both counters.
- `stall`  out  3  one-hot stall code (`STALL_NONE`/`STALL_IF`/`STALL_ID`/`STALL_MEM`); combinational.
- `clear`  out  1  flush IF/ID and ID/EX to NOP on the next edge; combinational.
- `redirect_valid`  out  1  fetch must load `redirect_pc`; equals `clear`.
- `redirect_pc`  out  32  redirect target.
- `cnt_stall`  out  CNT_W  cycles with `stall != STALL_NONE` and `rdy_in` high; registered.
- `cnt_flush`  out  CNT_W  number of `clear` pulses issued; registered.

## Operation
- Stall codes: `STALL_NONE` = 000, `STALL_IF` = 001, `STALL_ID` = 010, `STALL_MEM` = 100. `STALL_MASK_IDEX_EXMEM` = 100.
- FSM states:
  - RUN (reset state).
  - FLUSH_PEND: a jump is captured while MEM stalls.
- Priority in RUN, highest first:
  1. `rdy_in` low: `stall` = `STALL_MEM`, `clear` = 0. State, captured target and counters are held.
  2. `mem_stall_req`: `stall` = `STALL_MEM`. If `ex_jump` is also high, capture `ex_jump_pc` into `pend_pc` and go to FLUSH_PEND. `clear` = 0.
  3. `ex_jump`: `clear` = 1, `redirect_pc` = `ex_jump_pc`, `stall` = `STALL_NONE`. `id_load_use` and `if_stall_req` are ignored because those instructions are wrong-path.
  4. `id_load_use`: `stall` = `STALL_ID`. ID/EX inserts a bubble while IF/ID and PC hold.
  5. `if_stall_req`: `stall` = `STALL_IF`.
  6. Otherwise: `STALL_NONE`.
- FLUSH_PEND:
  - While `mem_stall_req` is high or `rdy_in` is low: `stall` = `STALL_MEM`, `clear` = 0. `ex_jump` is ignored (EX is frozen and reasserts the same jump); `pend_pc` is not overwritten.
  - First cycle with `mem_stall_req` low and `rdy_in` high: `clear` = 1, `redirect_pc` = `pend_pc`, `stall` = `STALL_NONE`, then return to RUN.
- `redirect_pc` is 0 whenever `redirect_valid` is 0.
- Counters:
  - Both saturate at all-ones and never wrap.
  - `perf_clr` has priority over increment; both counters go to 0 on the next edge.
  - `cnt_flush` increments on every cycle with `clear` = 1 (at most one per cycle).
- Reset (asynchronous, any time):
  - state = RUN, `pend_pc` = 0, both counters = 0.
  - While `rst_in` is low, combinational outputs are forced to `stall` = 000, `clear` = 0, `redirect_valid` = 0, `redirect_pc` = 0.
  - A pending flush is dropped.

## Timing
- `stall`, `clear`, `redirect_*` are same-cycle combinational functions of the inputs and the registered state. There are no combinational paths between the requesters other than through this block.
- A jump in EX with no MEM stall flushes on the edge ending that cycle: zero added latency, exactly one `clear` cycle.
- A jump under MEM stall flushes in the first cycle after the stall releases. This is exactly one `clear` pulse regardless of stall length.
- A load-use stall lasts exactly as long as `id_load_use` is high. A single-cycle request gives one bubble.
- State and counter updates occur only on `clk_in` rising edges with `rst_in` high.

## Structure
- Stall code and mask constants go in the shared defines header, alongside `ZeroWord`/opcode defines, because the pipeline registers already consume them.
- FSM state encodings stay local.
- One sub-module: `sat_counter` (parameter `W`; ports `clk_in`, `rst_in`, `clr`, `inc`, `q`), instantiated twice.

## Test plan
- Idle: all requests low for 10 cycles -> `stall` = 000, `clear` = 0, `cnt_stall` = 0.
- Load-use: `id_load_use` for 1 cycle -> `stall` = 010 for 1 cycle, `cnt_stall` = 1, no clear.
- Jump beats load-use: `ex_jump` = 1, `ex_jump_pc` = 0x0000_1040, `id_load_use` = 1 in the same cycle -> `clear` = 1, `redirect_pc` = 0x1040, `stall` = 000, `cnt_flush` = 1.
- Jump under MEM stall: `mem_stall_req` high for 4 cycles with `ex_jump` (pc 0x200) in the first cycle, and `ex_jump` (pc 0x300) asserted in cycle 3 -> `stall` = 100 for 4 cycles, then exactly one `clear` cycle with `redirect_pc` = 0x200; `cnt_flush` = 1.
- `rdy_in` low for 3 cycles during FLUSH_PEND -> `stall` = 100, no counter change; flush is issued after `rdy_in` and MEM release.
- Async reset asserted mid-FLUSH_PEND (between clock edges) -> outputs zero immediately; after release, no `clear` appears and counters read 0. Preload the counter near all-ones and verify `cnt_stall` saturates.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline defines: stall codes consumed by the pipeline registers and common word constants.
package pipe_hazard_ctrl_pkg;

  localparam logic [2:0]  STALL_NONE            = 3'b000;
  localparam logic [2:0]  STALL_IF              = 3'b001;
  localparam logic [2:0]  STALL_ID              = 3'b010;
  localparam logic [2:0]  STALL_MEM             = 3'b100;
  // Stages that freeze their pipeline registers under a MEM stall
  localparam logic [2:0]  STALL_MASK_IDEX_EXMEM = 3'b100;

  localparam logic [31:0] ZeroWord              = 32'h0000_0000;

  function automatic logic stall_active(input logic [2:0] code);
    return code != STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && ~&cnt_q)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler: merges IF/ID/MEM stall requests and EX redirects, defers
// a redirect that arrives under a MEM stall, and counts stall cycles and flushes.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             if_stall_req,
  input  logic             id_load_use,
  input  logic             mem_stall_req,
  input  logic             ex_jump,
  input  logic [31:0]      ex_jump_pc,
  input  logic             perf_clr,
  output logic [2:0]       stall,
  output logic             clear,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic {RUN, FLUSH_PEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [2:0]  stall_c;
  logic        clear_c;
  logic [31:0] rpc_c;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    stall_c   = STALL_NONE;
    clear_c   = 1'b0;
    rpc_c     = ZeroWord;
    if (!rst_in) begin
      // outputs stay at their quiet defaults while reset is held
    end else if (!rdy_in) begin
      stall_c = STALL_MEM;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_stall_req) begin
            stall_c = STALL_MEM;
            if (ex_jump) begin
              pend_pc_d = ex_jump_pc;
              state_d   = FLUSH_PEND;
            end
          end else if (ex_jump) begin
            // load-use / fetch stalls belong to wrong-path instructions here
            clear_c = 1'b1;
            rpc_c   = ex_jump_pc;
          end else if (id_load_use) begin
            stall_c = STALL_ID;
          end else if (if_stall_req) begin
            stall_c = STALL_IF;
          end
        end
        FLUSH_PEND: begin
          // EX is frozen and keeps reasserting its jump; the captured target stands
          if (mem_stall_req) begin
            stall_c = STALL_MEM;
          end else begin
            clear_c = 1'b1;
            rpc_c   = pend_pc_q;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= RUN;
      pend_pc_q <= ZeroWord;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign stall          = stall_c;
  assign clear          = clear_c;
  assign redirect_valid = clear_c;
  assign redirect_pc    = rpc_c;

  logic inc_stall;
  assign inc_stall = rdy_in & stall_active(stall_c);

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (perf_clr),
    .inc    (inc_stall),
    .q      (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (perf_clr),
    .inc    (clear_c),
    .q      (cnt_flush)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a narrow counter so saturation is reachable.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rdy, ifs, lu, ms, ej, pclr;
  logic [31:0]   ejpc;
  logic [2:0]    stall;
  logic          clear, rv;
  logic [31:0]   rpc;
  logic [CW-1:0] cnt_stall, cnt_flush;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .rdy_in         (rdy),
    .if_stall_req   (ifs),
    .id_load_use    (lu),
    .mem_stall_req  (ms),
    .ex_jump        (ej),
    .ex_jump_pc     (ejpc),
    .perf_clr       (pclr),
    .stall          (stall),
    .clear          (clear),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .cnt_stall      (cnt_stall),
    .cnt_flush      (cnt_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // check all combinational outputs at once
  task automatic outs(input string tag, input logic [2:0] s, input logic c, input logic [31:0] pc);
    chk({tag, ".stall"}, {29'd0, stall}, {29'd0, s});
    chk({tag, ".clear"}, {31'd0, clear}, {31'd0, c});
    chk({tag, ".rv"},    {31'd0, rv},    {31'd0, c});
    chk({tag, ".rpc"},   rpc,            pc);
  endtask

  task automatic cnts(input string tag, input int s, input int f);
    chk({tag, ".cnt_stall"}, {28'd0, cnt_stall}, s);
    chk({tag, ".cnt_flush"}, {28'd0, cnt_flush}, f);
  endtask

  // advance one edge; inputs then change and outputs are sampled away from the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rdy = 1'b1; ifs = 1'b0; lu = 1'b0; ms = 1'b0; ej = 1'b0; ejpc = 32'h0; pclr = 1'b0;
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    ifs = 1'b1; ej = 1'b1; ejpc = 32'hDEAD_BEEF;
    #2;
    outs("reset", 3'b000, 1'b0, 32'h0);
    cnts("reset", 0, 0);
    idle_in();
    #10 rst_n = 1'b1;
    cyc();

    // idle
    for (int i = 0; i < 10; i++) begin
      #1 outs("idle", 3'b000, 1'b0, 32'h0);
      cyc();
    end
    cnts("idle", 0, 0);

    // single-cycle load-use
    lu = 1'b1;
    #1 outs("lu", 3'b010, 1'b0, 32'h0);
    cyc();
    lu = 1'b0;
    #1 outs("lu_end", 3'b000, 1'b0, 32'h0);
    cnts("lu", 1, 0);

    // fetch stall alone
    ifs = 1'b1;
    #1 outs("ifs", 3'b001, 1'b0, 32'h0);
    cyc();
    ifs = 1'b0;
    cnts("ifs", 2, 0);

    // jump beats load-use and fetch stall
    ej = 1'b1; ejpc = 32'h0000_1040; lu = 1'b1; ifs = 1'b1;
    #1 outs("jmp", 3'b000, 1'b1, 32'h0000_1040);
    cyc();
    idle_in();
    #1 outs("jmp_end", 3'b000, 1'b0, 32'h0);
    cnts("jmp", 2, 1);

    // jump under 4-cycle MEM stall, second jump in cycle 3 ignored
    ms = 1'b1; ej = 1'b1; ejpc = 32'h200;
    #1 outs("mj1", 3'b100, 1'b0, 32'h0);
    cyc();
    ej = 1'b0;
    #1 outs("mj2", 3'b100, 1'b0, 32'h0);
    cyc();
    ej = 1'b1; ejpc = 32'h300;
    #1 outs("mj3", 3'b100, 1'b0, 32'h0);
    cyc();
    ej = 1'b0;
    #1 outs("mj4", 3'b100, 1'b0, 32'h0);
    cyc();
    ms = 1'b0; ej = 1'b1; ejpc = 32'h300;
    #1 outs("mj_flush", 3'b000, 1'b1, 32'h200);
    cyc();
    idle_in();
    #1 outs("mj_after", 3'b000, 1'b0, 32'h0);
    cnts("mj", 6, 2);

    // rdy low for 3 cycles during FLUSH_PEND
    ms = 1'b1; ej = 1'b1; ejpc = 32'h400;
    #1 outs("rp_cap", 3'b100, 1'b0, 32'h0);
    cyc();
    ms = 1'b0; ej = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 outs("rp_frz", 3'b100, 1'b0, 32'h0);
      cyc();
    end
    cnts("rp_frz", 7, 2);
    rdy = 1'b1; ms = 1'b1;
    #1 outs("rp_mem", 3'b100, 1'b0, 32'h0);
    cyc();
    ms = 1'b0;
    #1 outs("rp_flush", 3'b000, 1'b1, 32'h400);
    cyc();
    #1 outs("rp_after", 3'b000, 1'b0, 32'h0);
    cnts("rp", 8, 3);

    // async reset mid-FLUSH_PEND drops the pending flush
    ms = 1'b1; ej = 1'b1; ejpc = 32'h500;
    cyc();
    ms = 1'b0; ej = 1'b0;
    #1 outs("ar_pend", 3'b000, 1'b1, 32'h500);
    rst_n = 1'b0;
    #1 outs("ar_in", 3'b000, 1'b0, 32'h0);
    cnts("ar_in", 0, 0);
    rst_n = 1'b1;
    #1 outs("ar_rel", 3'b000, 1'b0, 32'h0);
    cyc();
    #1 outs("ar_post", 3'b000, 1'b0, 32'h0);
    cnts("ar_post", 0, 0);

    // cnt_stall saturation at all-ones
    ifs = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    #1 outs("sat", 3'b001, 1'b0, 32'h0);
    cnts("sat", 15, 0);

    // perf_clr beats increment
    pclr = 1'b1;
    cyc();
    pclr = 1'b0; ifs = 1'b0;
    cnts("pclr", 0, 0);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

endmodule
